// File: rtl/ysyx_25020037_gpr_sb_pkg.sv
//------------------------------------------------------------------------------
// +--------------------------------------------------------------------------+
// | Module  : ysyx_25020037_gpr_sb_pkg                                       |
// | Purpose : shared defaults, counter opcode enum and bus-width helpers for |
// |           the GPR scoreboard.                                            |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
//------------------------------------------------------------------------------
`default_nettype none

package ysyx_25020037_gpr_sb_pkg;

`include "ysyx_25020037_config.vh"

  localparam int DEF_XLEN   = `YSYX_25020037_XLEN;
  localparam int DEF_NR_REG = `YSYX_25020037_NR_REG;
  localparam int DEF_PEND_W = `YSYX_25020037_PEND_W;

  // Action taken by a pending counter on the next edge.
  typedef enum logic [1:0] {
    CNT_HOLD = 2'd0,
    CNT_INC  = 2'd1,
    CNT_DEC  = 2'd2,
    CNT_CLR  = 2'd3
  } cnt_op_e;

  function automatic int iss_bus_w(input int aw);
    return `YSYX_25020037_ISS_BUS_W(aw);
  endfunction

  function automatic int wb_bus_w(input int aw, input int xl);
    return `YSYX_25020037_WB_BUS_W(aw, xl);
  endfunction

endpackage

`default_nettype wire

// File: rtl/ysyx_25020037_config.vh
//------------------------------------------------------------------------------
// ysyx_25020037_config.vh
// Shared configuration for the GPR scoreboard: default data width and register
// count, plus the bit widths of the packed issue and write-back groups.
// Issue group     : {rd_wen, rd, rs2, rs1}
// Write-back group: {wb_valid, wb_wen, wb_rd, wb_data}
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none
`ifndef YSYX_25020037_CONFIG_VH
`define YSYX_25020037_CONFIG_VH

`define YSYX_25020037_XLEN    32
`define YSYX_25020037_NR_REG  16
`define YSYX_25020037_PEND_W  2

// Width of the packed issue group for a given register-index width.
`define YSYX_25020037_ISS_BUS_W(aw)     (3 * (aw) + 1)
// Width of the packed write-back group for a given index and data width.
`define YSYX_25020037_WB_BUS_W(aw, xl)  ((aw) + (xl) + 2)

`endif
`default_nettype wire

// File: rtl/ysyx_25020037_pend_cnt.sv
//------------------------------------------------------------------------------
// +--------------------------------------------------------------------------+
// | Module  : ysyx_25020037_pend_cnt                                         |
// | Purpose : per-register saturating up/down counter of in-flight writers.  |
// | Ports   : clk, rst (async, active high)                                  |
// |           flush  - clear on next edge, overrides inc/dec                 |
// |           inc    - one more writer issued                                |
// |           dec    - one writer wrote back                                 |
// |           cnt    - current count                                         |
// |           zero/full - count is 0 / count is 2^PEND_W-1                    |
// |           err    - decrement requested while count is 0                  |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
//------------------------------------------------------------------------------
`default_nettype none

module ysyx_25020037_pend_cnt
  import ysyx_25020037_gpr_sb_pkg::*;
#(
  parameter int PEND_W = 2
)(
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              inc,
  input  logic              dec,
  output logic [PEND_W-1:0] cnt,
  output logic              zero,
  output logic              full,
  output logic              err
);

  localparam logic [PEND_W-1:0] c_CNT_MAX = '1;

  logic [PEND_W-1:0] r_cnt;
  cnt_op_e           w_op;

  assign zero = (r_cnt == '0);
  assign full = (r_cnt == c_CNT_MAX);
  // A write-back with no recorded writer is reported even if an issue to the
  // same register lands in the same cycle.
  assign err  = dec & zero;
  assign cnt  = r_cnt;

  always_comb begin
    w_op = CNT_HOLD;
    if (flush) begin
      w_op = CNT_CLR;
    end else if (inc && !dec && !full) begin
      w_op = CNT_INC;
    end else if (dec && !inc && !zero) begin
      w_op = CNT_DEC;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else begin
      case (w_op)
        CNT_INC:  r_cnt <= r_cnt + 1'b1;
        CNT_DEC:  r_cnt <= r_cnt - 1'b1;
        CNT_CLR:  r_cnt <= '0;
        default:  r_cnt <= r_cnt;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/ysyx_25020037_gpr_sb.sv
//------------------------------------------------------------------------------
// +--------------------------------------------------------------------------+
// | Module  : ysyx_25020037_gpr_sb                                           |
// | Purpose : general-purpose register file with a per-register scoreboard   |
// |           of in-flight writers; stalls issue on RAW hazards and full     |
// |           counters.                                                      |
// | Ports   : clk, rst (async, active high)                                  |
// |           iss_*  - issue handshake, source/destination indices, operands |
// |           wb_*   - write-back beat                                       |
// |           flush  - drop every in-flight writer                           |
// |           pend_any - any register pending; sb_err - sticky underflow     |
// | Option  : YSYX_25020037_GPR_BYPASS_EN forwards a same-cycle write-back   |
// |           that retires the last writer of a source to the read port.     |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
//------------------------------------------------------------------------------
`default_nettype none

module ysyx_25020037_gpr_sb
  import ysyx_25020037_gpr_sb_pkg::*;
#(
  parameter  int XLEN   = DEF_XLEN,
  parameter  int NR_REG = DEF_NR_REG,   // 16 or 32 only
  parameter  int PEND_W = DEF_PEND_W,
  localparam int AW     = $clog2(NR_REG)
)(
  input  logic            clk,
  input  logic            rst,
  input  logic            iss_valid,
  output logic            iss_ready,
  input  logic [AW-1:0]   iss_rs1,
  input  logic [AW-1:0]   iss_rs2,
  input  logic [AW-1:0]   iss_rd,
  input  logic            iss_rd_wen,
  output logic [XLEN-1:0] rs1_data,
  output logic [XLEN-1:0] rs2_data,
  input  logic            wb_valid,
  input  logic            wb_wen,
  input  logic [AW-1:0]   wb_rd,
  input  logic [XLEN-1:0] wb_data,
  input  logic            flush,
  output logic            pend_any,
  output logic            sb_err
);

  localparam int c_ISS_W = iss_bus_w(AW);
  localparam int c_WB_W  = wb_bus_w(AW, XLEN);

  // Packed issue / write-back groups and their fields.
  logic [c_ISS_W-1:0] w_iss_bus;
  logic [c_WB_W-1:0]  w_wb_bus;
  logic [AW-1:0]      w_rs1, w_rs2, w_rd, w_wb_rd;
  logic               w_rd_wen, w_wb_valid, w_wb_wen;
  logic [XLEN-1:0]    w_wb_data;

  assign w_iss_bus  = {iss_rd_wen, iss_rd, iss_rs2, iss_rs1};
  assign w_rs1      = w_iss_bus[AW-1:0];
  assign w_rs2      = w_iss_bus[2*AW-1:AW];
  assign w_rd       = w_iss_bus[3*AW-1:2*AW];
  assign w_rd_wen   = w_iss_bus[3*AW];

  assign w_wb_bus   = {wb_valid, wb_wen, wb_rd, wb_data};
  assign w_wb_data  = w_wb_bus[XLEN-1:0];
  assign w_wb_rd    = w_wb_bus[XLEN+AW-1:XLEN];
  assign w_wb_wen   = w_wb_bus[XLEN+AW];
  assign w_wb_valid = w_wb_bus[XLEN+AW+1];

  logic [XLEN-1:0]   r_regs [NR_REG];
  logic [PEND_W-1:0] w_cnt  [NR_REG];
  logic [NR_REG-1:0] w_zero;
  logic [NR_REG-1:0] w_full;
  logic [NR_REG-1:0] w_err;
  logic              r_sb_err;
  logic              w_wb_we;
  logic              w_iss_fire;
  logic              w_rs1_busy;
  logic              w_rs2_busy;
  logic              w_pend_any;

  // Writes to x0 are dropped entirely: no data, no counter activity.
  assign w_wb_we    = w_wb_valid & w_wb_wen & (w_wb_rd != '0);
  assign w_iss_fire = iss_valid & iss_ready;

  //--------------------------------------------------------------------------
  // Pending counters; x0 is tied to a permanently idle slot.
  //--------------------------------------------------------------------------
  assign w_cnt[0]  = '0;
  assign w_zero[0] = 1'b1;
  assign w_full[0] = 1'b0;
  assign w_err[0]  = 1'b0;

  for (genvar gi = 1; gi < NR_REG; gi++) begin : g_cnt
    logic w_inc;
    logic w_dec;

    assign w_inc = w_iss_fire & w_rd_wen & (w_rd == AW'(gi));
    assign w_dec = w_wb_we & (w_wb_rd == AW'(gi));

    ysyx_25020037_pend_cnt #(
      .PEND_W (PEND_W)
    ) u_pend_cnt (
      .clk   (clk),
      .rst   (rst),
      .flush (flush),
      .inc   (w_inc),
      .dec   (w_dec),
      .cnt   (w_cnt[gi]),
      .zero  (w_zero[gi]),
      .full  (w_full[gi]),
      .err   (w_err[gi])
    );
  end

  always_comb begin
    w_pend_any = 1'b0;
    for (int i = 0; i < NR_REG; i++) begin
      w_pend_any = w_pend_any | (|w_cnt[i]);
    end
  end

  assign pend_any = w_pend_any;

  //--------------------------------------------------------------------------
  // Register array. Entry 0 is reset to zero and never written.
  //--------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NR_REG; i++) begin
        r_regs[i] <= '0;
      end
    end else if (w_wb_we) begin
      r_regs[w_wb_rd] <= w_wb_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sb_err <= 1'b0;
    end else begin
      r_sb_err <= r_sb_err | (|w_err);
    end
  end

  assign sb_err = r_sb_err;

  //--------------------------------------------------------------------------
  // Read ports and RAW hazard detection.
  //--------------------------------------------------------------------------
`ifdef YSYX_25020037_GPR_BYPASS_EN
  localparam logic [PEND_W-1:0] c_ONE = PEND_W'(1);

  // A source whose only outstanding writer retires this cycle is satisfied
  // by the write-back bus. w_wb_we already excludes x0.
  logic w_rs1_hit, w_rs2_hit;

  assign w_rs1_hit  = w_wb_we & (w_wb_rd == w_rs1);
  assign w_rs2_hit  = w_wb_we & (w_wb_rd == w_rs2);
  assign w_rs1_busy = ~w_zero[w_rs1] & ~(w_rs1_hit & (w_cnt[w_rs1] == c_ONE));
  assign w_rs2_busy = ~w_zero[w_rs2] & ~(w_rs2_hit & (w_cnt[w_rs2] == c_ONE));

  always_comb begin
    rs1_data = r_regs[w_rs1];
    if (w_rs1 == '0) begin
      rs1_data = '0;
    end else if (w_rs1_hit) begin
      rs1_data = w_wb_data;
    end
  end

  always_comb begin
    rs2_data = r_regs[w_rs2];
    if (w_rs2 == '0) begin
      rs2_data = '0;
    end else if (w_rs2_hit) begin
      rs2_data = w_wb_data;
    end
  end
`else
  assign w_rs1_busy = ~w_zero[w_rs1];
  assign w_rs2_busy = ~w_zero[w_rs2];

  always_comb begin
    rs1_data = r_regs[w_rs1];
    if (w_rs1 == '0) begin
      rs1_data = '0;
    end
  end

  always_comb begin
    rs2_data = r_regs[w_rs2];
    if (w_rs2 == '0) begin
      rs2_data = '0;
    end
  end
`endif

  // Ready is deliberately independent of iss_valid so decode can probe it.
  assign iss_ready = ~flush & ~w_rs1_busy & ~w_rs2_busy
                   & ~(w_rd_wen & w_full[w_rd]);

endmodule

`default_nettype wire

// File: tb/tb_ysyx_25020037_gpr_sb.sv
//------------------------------------------------------------------------------
// +--------------------------------------------------------------------------+
// | Module  : tb_ysyx_25020037_gpr_sb                                        |
// | Purpose : directed self-checking bench for the GPR scoreboard, with a    |
// |           16-register and a 32-register instance.                        |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
//------------------------------------------------------------------------------
`default_nettype none

module tb_ysyx_25020037_gpr_sb;

`ifdef YSYX_25020037_GPR_BYPASS_EN
  localparam bit c_BYP = 1'b1;
`else
  localparam bit c_BYP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // 16-register instance
  logic        iss_valid, iss_ready, iss_rd_wen;
  logic [3:0]  iss_rs1, iss_rs2, iss_rd, wb_rd;
  logic [31:0] rs1_data, rs2_data, wb_data;
  logic        wb_valid, wb_wen, flush, pend_any, sb_err;

  // 32-register instance
  logic        b_iss_valid, b_iss_ready, b_iss_rd_wen;
  logic [4:0]  b_iss_rs1, b_iss_rs2, b_iss_rd, b_wb_rd;
  logic [31:0] b_rs1_data, b_rs2_data, b_wb_data;
  logic        b_wb_valid, b_wb_wen, b_flush, b_pend_any, b_sb_err;

  ysyx_25020037_gpr_sb dut (
    .clk(clk), .rst(rst),
    .iss_valid(iss_valid), .iss_ready(iss_ready),
    .iss_rs1(iss_rs1), .iss_rs2(iss_rs2), .iss_rd(iss_rd), .iss_rd_wen(iss_rd_wen),
    .rs1_data(rs1_data), .rs2_data(rs2_data),
    .wb_valid(wb_valid), .wb_wen(wb_wen), .wb_rd(wb_rd), .wb_data(wb_data),
    .flush(flush), .pend_any(pend_any), .sb_err(sb_err)
  );

  ysyx_25020037_gpr_sb #(.NR_REG(32)) dut32 (
    .clk(clk), .rst(rst),
    .iss_valid(b_iss_valid), .iss_ready(b_iss_ready),
    .iss_rs1(b_iss_rs1), .iss_rs2(b_iss_rs2), .iss_rd(b_iss_rd), .iss_rd_wen(b_iss_rd_wen),
    .rs1_data(b_rs1_data), .rs2_data(b_rs2_data),
    .wb_valid(b_wb_valid), .wb_wen(b_wb_wen), .wb_rd(b_wb_rd), .wb_data(b_wb_data),
    .flush(b_flush), .pend_any(b_pend_any), .sb_err(b_sb_err)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    iss_valid = 0; iss_rd_wen = 0; iss_rs1 = 0; iss_rs2 = 0; iss_rd = 0;
    wb_valid = 0; wb_wen = 0; wb_rd = 0; wb_data = 0; flush = 0;
  endtask

  task automatic b_idle();
    b_iss_valid = 0; b_iss_rd_wen = 0; b_iss_rs1 = 0; b_iss_rs2 = 0; b_iss_rd = 0;
    b_wb_valid = 0; b_wb_wen = 0; b_wb_rd = 0; b_wb_data = 0; b_flush = 0;
  endtask

  task automatic issue_rd(input logic [3:0] rd);
    idle();
    iss_valid = 1; iss_rd_wen = 1; iss_rd = rd;
  endtask

  task automatic wb(input logic [3:0] rd, input logic [31:0] d);
    wb_valid = 1; wb_wen = 1; wb_rd = rd; wb_data = d;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1);
  end

  initial begin
    idle();
    b_idle();
    rst = 1;
    #2;
    // Reset state
    chk("rst_ready",    iss_ready, 1);
    chk("rst_pend_any", pend_any,  0);
    chk("rst_rs1",      rs1_data,  0);
    chk("rst_rs2",      rs2_data,  0);
    chk("rst_sb_err",   sb_err,    0);
    chk("rst32_ready",  b_iss_ready, 1);
    repeat (2) step();
    rst = 0;

    // Issue rd=5, then RAW stall on rs1=5, resolved by write-back 0x1234
    issue_rd(4'd5);
    #1 chk("i5_ready", iss_ready, 1);
    step();
    idle();
    #1 chk("i5_pend_any", pend_any, 1);
    iss_valid = 1; iss_rs1 = 5;
    #1 chk("raw5_stall", iss_ready, 0);
    step();
    iss_valid = 1; iss_rs1 = 5;
    wb(4'd5, 32'h1234);
    #1 chk("raw5_wb_ready", iss_ready, c_BYP);
    if (c_BYP) chk("raw5_bypass_data", rs1_data, 32'h1234);
    step();
    idle();
    iss_valid = 1; iss_rs1 = 5;
    #1 chk("raw5_after_ready", iss_ready, 1);
    chk("raw5_after_data", rs1_data, 32'h1234);
    chk("raw5_pend_any", pend_any, 0);
    step();

    // Counter saturation on rd=7
    for (int k = 0; k < 3; k++) begin
      issue_rd(4'd7);
      #1 chk("sat7_ready", iss_ready, 1);
      step();
    end
    issue_rd(4'd7);
    #1 chk("sat7_full_stall", iss_ready, 0);
    step();
    idle();
    wb(4'd7, 32'h77);
    step();
    issue_rd(4'd7);
    #1 chk("sat7_after_wb_ready", iss_ready, 1);
    step();

    // Same-cycle issue and write-back to rd=3 keeps pending[3]=1
    issue_rd(4'd3);
    step();
    issue_rd(4'd3);
    wb(4'd3, 32'h33);
    #1 chk("same3_ready", iss_ready, 1);
    step();
    idle();
    iss_valid = 1; iss_rs1 = 3;
    #1 chk("same3_still_pending", iss_ready, 0);
    wb(4'd3, 32'h3333);
    #1 chk("same3_wb_ready", iss_ready, c_BYP);
    step();
    idle();
    iss_valid = 1; iss_rs1 = 3;
    #1 chk("same3_drained_ready", iss_ready, 1);
    chk("same3_data", rs1_data, 32'h3333);
    chk("same3_no_err", sb_err, 0);
    step();

    // x0 write ignored; write to non-pending x9 sets sb_err
    idle();
    wb(4'd0, 32'hFFFF_FFFF);
    step();
    idle();
    #1 chk("x0_reads_zero", rs1_data, 0);
    chk("x0_no_err", sb_err, 0);
    wb(4'd9, 32'hABCD);
    step();
    idle();
    iss_rs2 = 9;
    #1 chk("x9_err", sb_err, 1);
    chk("x9_data", rs2_data, 32'hABCD);

    // Pending on 2, 4, 6 then flush (with a write-back to 4 in the flush cycle)
    issue_rd(4'd2); step();
    issue_rd(4'd4); step();
    issue_rd(4'd6); step();
    idle();
    iss_rs1 = 2; iss_rs2 = 6;
    #1 chk("fl_pend_any", pend_any, 1);
    chk("fl_stall", iss_ready, 0);
    idle();
    iss_valid = 1; flush = 1;
    wb(4'd4, 32'h4444);
    #1 chk("fl_ready_low", iss_ready, 0);
    step();
    idle();
    #1 chk("fl_pend_any_clr", pend_any, 0);
    iss_rs1 = 2; iss_rs2 = 6;
    #1 chk("fl_released", iss_ready, 1);
    iss_rs1 = 4; iss_rd = 7; iss_rd_wen = 1;
    #1 chk("fl_rd7_ready", iss_ready, 1);
    chk("fl_wb_data", rs1_data, 32'h4444);
    chk("fl_err_sticky", sb_err, 1);

    // Asynchronous reset between edges with a counter pending
    issue_rd(4'd5);
    step();
    idle();
    iss_valid = 1; iss_rs1 = 5; iss_rs2 = 4;
    #1 chk("ar_pend_before", pend_any, 1);
    #1 rst = 1;
    #1;
    chk("ar_pend_any", pend_any, 0);
    chk("ar_ready", iss_ready, 1);
    chk("ar_rs1", rs1_data, 0);
    chk("ar_rs2", rs2_data, 0);
    chk("ar_sb_err", sb_err, 0);
    step();
    rst = 0;
    idle();

    // 32-register instance with rd=31
    b_iss_valid = 1; b_iss_rd_wen = 1; b_iss_rd = 31;
    #1 chk("b31_ready", b_iss_ready, 1);
    step();
    b_idle();
    b_iss_valid = 1; b_iss_rs1 = 31;
    #1 chk("b31_pend_any", b_pend_any, 1);
    chk("b31_stall", b_iss_ready, 0);
    step();
    b_idle();
    b_wb_valid = 1; b_wb_wen = 1; b_wb_rd = 31; b_wb_data = 32'hDEAD_BEEF;
    step();
    b_idle();
    b_iss_rs1 = 31;
    #1 chk("b31_ready_after", b_iss_ready, 1);
    chk("b31_data", b_rs1_data, 32'hDEAD_BEEF);
    chk("b31_no_err", b_sb_err, 0);
    b_iss_valid = 1; b_iss_rd_wen = 1; b_iss_rd = 31;
    step();
    b_idle();
    b_iss_valid = 1; b_iss_rs1 = 31;
    #1 chk("b31_pend_again", b_pend_any, 1);
    #1 rst = 1;
    #1;
    chk("b31_ar_pend_any", b_pend_any, 0);
    chk("b31_ar_ready", b_iss_ready, 1);
    chk("b31_ar_rs1", b_rs1_data, 0);
    step();
    rst = 0;
    b_idle();
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/ysyx_25020037_gpr_sb.md
YSYX_25020037_GPR_SB -- requirements
Module: ysyx_25020037_gpr_sb

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset, with ports named clk and rst as elsewhere in the codebase.
REQ-002 Parameters SHALL be (name, default, meaning):
- XLEN, 32, register data width.
- NR_REG, 16, register count; only 16 or 32 are legal.
- PEND_W, 2, width of the per-register pending counter.
REQ-003 AW SHALL equal log2(NR_REG).
REQ-004 Ports SHALL be (name, direction, width, meaning):
- clk, in, 1, clock.
- rst, in, 1, asynchronous active-high reset.
- iss_valid, in, 1, decode presents an instruction.
- iss_ready, out, 1, no hazard; issue accepted.
- iss_rs1, in, AW, source register 1 index.
- iss_rs2, in, AW, source register 2 index.
- iss_rd, in, AW, destination register index.
- iss_rd_wen, in, 1, instruction writes rd.
- rs1_data, out, XLEN, source 1 operand.
- rs2_data, out, XLEN, source 2 operand.
- wb_valid, in, 1, write-back beat.
- wb_wen, in, 1, write-back writes a register.
- wb_rd, in, AW, write-back destination.
- wb_data, in, XLEN, write-back value.
- flush, in, 1, discard all in-flight writes.
- pend_any, out, 1, OR of all pending counters.
- sb_err, out, 1, sticky error: write-back to a non-pending register.

Function
REQ-005 Register 0 SHALL read as zero, SHALL never be written, and SHALL never become pending.
REQ-006 rs1_data and rs2_data SHALL be combinational reads of the array; a write-back SHALL be visible in the array on the cycle after wb_valid.
REQ-007 Each register SHALL have a PEND_W-bit counter of in-flight writers.
REQ-008 Issue SHALL fire when iss_valid and iss_ready are both high.
REQ-009 On an issue fire with iss_rd_wen=1 and iss_rd≠0, pending[iss_rd] SHALL increment.
REQ-010 A write-back (wb_valid & wb_wen & wb_rd≠0) SHALL write wb_data and SHALL decrement pending[wb_rd].
REQ-011 An issue fire and a write-back to the same rd in one cycle SHALL leave the counter unchanged.
REQ-012 iss_ready SHALL be low if pending[iss_rs1]≠0 or pending[iss_rs2]≠0 (RAW hazard).
REQ-013 iss_ready SHALL also be low if iss_rd_wen=1 and pending[iss_rd] equals its maximum 2^PEND_W-1 (counter full).
REQ-014 iss_ready SHALL be low while flush is high.
REQ-015 iss_ready SHALL NOT depend on iss_valid.
REQ-016 A write-back to a register whose counter is 0 SHALL still write the data, SHALL leave the counter at 0, and SHALL set sb_err until reset.
REQ-017 Flush SHALL clear all counters on the next edge, overriding any same-cycle increment or decrement; a same-cycle write-back SHALL still write its data.
REQ-018 pend_any SHALL be a registered-state OR, and SHALL be low on the cycle after a flush.

Reset
REQ-019 Asserting rst, including mid-operation, SHALL immediately clear all registers, all counters and sb_err, dropping all in-flight writes.
REQ-020 During and after reset, iss_ready SHALL be 1 (flush low), pend_any SHALL be 0, and both read ports SHALL be 0.

Configuration
REQ-021 With macro YSYX_25020037_GPR_BYPASS_EN defined, a source matching a same-cycle write-back whose counter is 1 SHALL read wb_data and SHALL NOT cause a stall.
REQ-022 Without YSYX_25020037_GPR_BYPASS_EN, that source SHALL stall for that cycle and issue one cycle later from the array.

Structure
REQ-023 XLEN/NR_REG defaults and the bus-width constants of the issue and write-back groups SHALL live in the shared header ysyx_25020037_config.vh.
REQ-024 The per-register saturating up/down counter with async reset and flush SHALL be the sub-module ysyx_25020037_pend_cnt, instantiated NR_REG-1 times by generate.

Verification
REQ-025 Issue rd=5 -> pending[5]=1 and pend_any=1; issue rs1=5 stalls; write-back rd=5 with data 0x1234 -> issue proceeds and rs1_data=0x1234 (same cycle with bypass, next cycle without).
REQ-026 Three issues to rd=7 with PEND_W=2 -> the fourth issue to rd=7 stalls; one write-back to rd=7 -> issue accepted.
REQ-027 Same-cycle issue to rd=3 and write-back to rd=3 with pending[3]=1 -> pending[3] stays 1.
REQ-028 Write-back rd=0 with data 0xFFFF_FFFF -> rs1=0 reads 0 and sb_err stays 0; write-back rd=9 with pending[9]=0 -> sb_err=1 and data written.
REQ-029 Pending on registers 2, 4 and 6, then flush -> pend_any=0 next cycle and all stalls released.
REQ-030 Assert rst asynchronously between edges with pending counters non-zero -> outputs 0 and iss_ready=1 before the next clk edge; repeat the run with NR_REG=32 and rd=31.
